// File: rtl/image_row_writer.sv
// ---------------------------------------------------------------------------
// image_row_writer
//   Producer side of the 60x80 1-bpp image line memory. Collects a bit-serial
//   pixel stream (valid/ready) into an 80-pixel line, then presents the full
//   line on the memory write port (rowW/dataW). The memory has no write
//   enable: it writes rowW/dataW on every clock unless rowW equals the
//   reader's row. So rowW/dataW are held stable, and rd_row is watched to
//   know when a committed line has really landed.
//
//   Optional feature macro: IMAGE_ROW_WRITER_CLEAR_EN
//     defined   : after reset every row is zeroed (CLEAR sweep) before any
//                 pixel is accepted; clear_busy is high during the sweep.
//     undefined : reset goes straight to FILL; clear_busy is tied low. Row 0
//                 is still zeroed until the first commit because rowW/dataW
//                 reset to 0.
//
// Ports
//   clk        : system clock (memory samples its write port on posedge)
//   rst_n      : asynchronous active-low reset
//   pix_valid  : pixel offered
//   pix_data   : pixel value
//   pix_sof    : start of frame (row 0, col 0), valid with pix_valid
//   pix_ready  : pixel accepted when pix_valid && pix_ready at posedge
//   rd_row     : row currently addressed by the memory read port
//   rowW       : memory write row
//   dataW      : memory write data, bit c = pixel at column c
//   row_done   : 1-cycle pulse after a committed line has landed
//   clear_busy : high during the post-reset clear sweep
// ---------------------------------------------------------------------------
module image_row_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int RW   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_valid,
  input  logic            pix_data,
  input  logic            pix_sof,
  output logic            pix_ready,
  input  logic [RW-1:0]   rd_row,
  output logic [RW-1:0]   rowW,
  output logic [COLS-1:0] dataW,
  output logic            row_done,
  output logic            clear_busy
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

`ifdef IMAGE_ROW_WRITER_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_FILL;
`endif

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic [RW-1:0] LAST_COL = RW'(COLS-1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_row_w;
  logic [COLS-1:0] r_data_w;
  logic [COLS-1:0] r_shadow;
  logic [COLS-1:0] w_line;
  logic [RW-1:0]   r_col_cnt;
  logic [RW-1:0]   r_fill_row;
  logic            r_row_done;
  logic            r_pix_ready;

  logic w_land;
  logic w_accept;
  logic w_line_end;

  // A write lands on any edge where the writer's row is not the reader's row.
  // rd_row values >= ROWS never match a legal rowW, so they never collide.
  assign w_land     = (r_row_w != rd_row);
  assign w_accept   = pix_valid & r_pix_ready;
  // sof wins over line completion: an sof pixel always restarts at column 0.
  assign w_line_end = w_accept & ~pix_sof & (r_col_cnt == LAST_COL);

  // Shadow line with the currently offered pixel merged in at col_cnt.
  always_comb begin
    w_line            = r_shadow;
    w_line[r_col_cnt] = pix_data;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR:  if (w_land && (r_row_w == LAST_ROW)) w_state_nxt = S_FILL;
      S_FILL:   if (w_line_end)                      w_state_nxt = S_COMMIT;
      S_COMMIT: if (w_land)                          w_state_nxt = S_FILL;
      default:                                       w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_row_w     <= '0;
      r_data_w    <= '0;
      r_shadow    <= '0;
      r_col_cnt   <= '0;
      r_fill_row  <= '0;
      r_row_done  <= 1'b0;
      r_pix_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // ready is registered from the next state so it reflects state only and
      // stays low while reset is asserted, even when reset enters FILL.
      r_pix_ready <= (w_state_nxt == S_FILL);
      r_row_done  <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_data_w <= '0;
          // Row 59 is left on the port when entering FILL; it keeps being
          // rewritten with zeros until the first commit.
          if (w_land && (r_row_w != LAST_ROW)) r_row_w <= r_row_w + 1'b1;
        end
        S_FILL: begin
          if (w_accept) begin
            if (pix_sof) begin
              r_shadow[0] <= pix_data;
              r_col_cnt   <= RW'(1);
              r_fill_row  <= '0;
            end else if (r_col_cnt == LAST_COL) begin
              r_row_w   <= r_fill_row;
              r_data_w  <= w_line;
              r_col_cnt <= '0;
            end else begin
              r_shadow  <= w_line;
              r_col_cnt <= r_col_cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          if (w_land) begin
            r_row_done <= 1'b1;
            r_fill_row <= (r_fill_row == LAST_ROW) ? '0 : r_fill_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rowW      = r_row_w;
  assign dataW     = r_data_w;
  assign row_done  = r_row_done;
  assign pix_ready = r_pix_ready;

`ifdef IMAGE_ROW_WRITER_CLEAR_EN
  assign clear_busy = (r_state == S_CLEAR);
`else
  assign clear_busy = 1'b0;
`endif

endmodule

// File: doc/image_row_writer.md
Name: image_row_writer

Overview:
Producer side of the 60x80 1-bpp image line memory. It accepts a bit-serial pixel stream with a valid/ready handshake and packs 80 pixels into a line. It then drives the memory's write port (rowW, dataW) for that full line. The memory has no write enable, so it writes rowW/dataW on every clock unless rowW equals the reader's row. This block therefore holds rowW/dataW stable and tracks rd_row to know when a line has actually landed.

Parameters:
COLS, 80, pixels per line (width of dataW)
ROWS, 60, lines per frame
RW, 7, row/column index width

Ports:
clk  in  1  system clock; memory write port samples on posedge
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  pixel offered
pix_data  in  1  pixel value
pix_sof  in  1  sideband, valid with pix_valid; marks row 0 col 0
pix_ready  out  1  pixel accepted when pix_valid&&pix_ready at posedge
rd_row  in  RW  row currently addressed by the memory read port
rowW  out  RW  memory write row
dataW  out  COLS  memory write data; bit c = pixel at column c
row_done  out  1  1-cycle pulse: committed line written
clear_busy  out  1  high during post-reset clear sweep

Behaviour:
- Reset (async, rst_n=0): state=CLEAR (FILL without macro), rowW=0, dataW=0, pix_ready=0, row_done=0, clear_busy=1 (0 without macro), col_cnt=0, fill_row=0, shadow=0.
- A write "lands" at any posedge where rowW != rd_row. Both signals are sampled at the same edge as the memory.
- States: CLEAR, FILL, COMMIT.
- CLEAR: dataW=0. At each posedge where rowW != rd_row: if rowW==ROWS-1, go to FILL (rowW held at 59, dataW held at 0), else rowW++. If rowW==rd_row, hold. pix_ready=0. clear_busy=1 only in CLEAR.
- FILL: pix_ready=1. On accept, shadow[col_cnt] <= pix_data and col_cnt++.
  - If pix_sof is set on an accepted pixel, it is column 0 of row 0. The partial line is discarded: shadow bit 0 <= pix_data, col_cnt=1, fill_row=0.
  - On the accept with col_cnt==COLS-1 (the line is complete): next edge rowW<=fill_row, dataW<=completed line (including this pixel), col_cnt<=0, go to COMMIT.
  - rowW/dataW are unchanged throughout FILL. The memory re-writes the previous committed line, which is harmless.
- COMMIT: pix_ready=0.
  - At each posedge where rowW != rd_row: go to FILL, row_done=1 for the following cycle, fill_row <= (fill_row==ROWS-1) ? 0 : fill_row+1.
  - While rowW==rd_row: stay, no pulse. Minimum dwell is 1 cycle.
- Throughput: ≥81 cycles per line (80 accepts + 1 commit).
- Reset asserted mid-operation: immediate return to reset values. Partial and uncommitted lines are lost.
- pix_ready depends only on state; it never depends combinationally on pix_valid.
- rd_row values ≥ROWS are legal and never collide.

Optional Feature:
IMAGE_ROW_WRITER_CLEAR_EN
- Defined: CLEAR state exists. After reset, all 60 rows are zeroed before any pixel is accepted.
- Undefined: reset enters FILL directly and clear_busy is tied 0. rowW=0/dataW=0 are still driven, so memory row 0 is continuously zeroed until the first commit. Other rows keep their power-up contents.

Test Plan:
1. Macro on, rd_row=70 constant, release reset -> clear_busy=1 for exactly 60 cycles, rowW steps 0..59 with dataW=0, pix_ready=1 on the next cycle.
2. After clear, 80 back-to-back pixels, value = col%2, pix_sof on first -> the cycle after the 80th accept: rowW=0, dataW=0xAAAAAAAAAAAAAAAAAAAA, pix_ready=0. One cycle later row_done=1 and pix_ready=1.
3. Line for row 5 complete with rd_row=5 -> COMMIT held, no row_done, pix_ready=0. rd_row->6 -> commit at next edge, row_done pulse one cycle later.
4. Stream 61 full lines with sof only on the first -> lines 0..59 committed to rowW 0..59; the 61st commits to rowW=0; 61 row_done pulses.
5. 30 pixels into row 3, then a pixel with pix_sof=1 followed by 79 more -> commit to rowW=0 with bit 0 = sof pixel; no row-3 commit.
6. Assert rst_n=0 asynchronously mid-FILL (col_cnt=40) -> outputs at reset values without waiting for clk. After release, the clear sweep repeats and the old partial line is never written.
